seq_gen: RTL and testbench
==========================

Name: seq_gen

Overview:
Serial bit-pattern transmitter: the drive-side counterpart of the single-bit sequence detector. Loads a pattern of up to MAX_LEN bits and shifts it out LSB-first, one bit per clock, with a programmable repeat count. Feeds the detector's `in` port in block-level benches and in on-chip self-test paths.

Parameters:
MAX_LEN, 16, maximum pattern length in bits; LEN_W = $clog2(MAX_LEN).
REP_W, 4, width of the repeat-count field.
GAP_W, 2, width of the inter-bit gap count (used only with the optional feature).

Ports:
clk      in   1        system clock, rising edge.
rst_n    in   1        asynchronous active-low reset.
start    in   1        transmit request; sampled only while ready=1.
abort    in   1        synchronous abort; valid in any state.
pattern  in   MAX_LEN  bits to send; bit 0 goes first.
len_m1   in   LEN_W    pattern length minus 1 (0..MAX_LEN-1).
reps_m1  in   REP_W    number of pattern repetitions minus 1.
ready    out  1        idle, start accepted.
out      out  1        serial data bit, registered.
out_vld  out  1        out carries a pattern bit this cycle, registered.
done     out  1        one-cycle pulse after the final bit.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, ready=1, out=0, out_vld=0, done=0. Bit index, repeat count and LFSR are cleared or seeded.
- All outputs are registered. Whenever out_vld=0, out=0.
- States: IDLE, SEND, GAP (feature only), DONE.
- IDLE:
  - ready=1.
  - If start=1 and abort=0 at an edge, capture pattern, len_m1 and reps_m1, clear idx and rep, and go to SEND.
  - If start and abort are both high, abort wins and start is ignored.
- SEND:
  - out=pattern_q[idx], out_vld=1. First bit appears in the cycle after the start edge.
  - If idx<len_m1_q: idx++.
  - Else if rep<reps_m1_q: idx=0, rep++.
  - Else: go to DONE.
- DONE: done=1, out_vld=0 for exactly one cycle, then IDLE. ready returns the cycle after done.
- Total bits sent = (len_m1+1)*(reps_m1+1), back-to-back with no bubbles (feature off). Bits continue across repeat boundaries without gaps.
- start while ready=0 is ignored: no queueing, no effect on the captured values.
- Input changes after capture have no effect on the frame in flight.
- abort=1 in SEND, GAP or DONE: next cycle state=IDLE, out_vld=0, out=0, ready=1, no done pulse.
- len_m1=0, reps_m1=0: a single bit, then done.
- Maximum frame: MAX_LEN*2^REP_W bits. Counters must not wrap early: idx is LEN_W bits, rep is REP_W bits, and comparisons are exact equality.

Optional Feature:
- Macro: SEQ_GEN_GAP_EN.
- Defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 8'hA5 on reset; never all-zero) adds random idle gaps between bits.
  - After every bit except the frame's final bit, load g = lfsr[GAP_W-1:0] and step the LFSR once.
  - If g>0, enter GAP for g cycles with out_vld=0, out=0, then resume SEND. If g=0, the next bit follows immediately.
  - The LFSR keeps its state across frames and is reseeded only by reset.
  - abort is honoured in GAP.
- Undefined: no LFSR and no GAP state; output is strictly back-to-back as above.

Test Plan:
- Reset/idle: hold rst_n=0 for 5 cycles, release -> ready=1, out=0, out_vld=0, done=0. Assert rst_n=0 mid-SEND -> outputs return to reset values immediately, asynchronously.
- Single frame: pattern=16'h000D, len_m1=3, reps_m1=0, start at cycle 0 -> out_vld=1 in cycles 1-4 with out=1,0,1,1; done=1 in cycle 5; ready=1 in cycle 6.
- Repeat: pattern=16'h0002, len_m1=1, reps_m1=2 -> six back-to-back bits 0,1,0,1,0,1, then a single done pulse. Feed into the detector; its out matches the golden model.
- Full length: pattern=16'hB2C5, len_m1=15, reps_m1=15 -> 256 bits equal to the repeated LSB-first 16'hB2C5, with exactly one done.
- Abort/ignored start: start a frame with len_m1=7; pulse start at bit 2 -> no effect. Pulse abort at bit 4 -> IDLE next cycle with no done. start+abort together in IDLE -> stays IDLE.
- Feature on (SEQ_GEN_GAP_EN): len_m1=3, reps_m1=0 -> gap lengths match the LFSR model from seed 8'hA5, no gap after the last bit, and the bit order is unchanged.

Source files
------------

// File: rtl/seq_gen_if.sv
// seq_gen bus: start/abort request, pattern config, serial output and status.
// Ports: start, abort, pattern, len_m1, reps_m1 -> gen; ready, out, out_vld, done <- gen.
interface seq_gen_if #(
  parameter int MAX_LEN = 16,
  parameter int REP_W   = 4
);
  localparam int LEN_W = $clog2(MAX_LEN);

  logic               start;
  logic               abort;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   len_m1;
  logic [REP_W-1:0]   reps_m1;
  logic               ready;
  logic               out;
  logic               out_vld;
  logic               done;

  modport master (
    output start, abort, pattern, len_m1, reps_m1,
    input  ready, out, out_vld, done
  );

  modport slave (
    input  start, abort, pattern, len_m1, reps_m1,
    output ready, out, out_vld, done
  );
endinterface

// File: rtl/seq_gen.sv
// Serial pattern transmitter: shifts a captured pattern out LSB-first with repeats.
// Ports: clk, rst_n (async low), bus (seq_gen_if.slave). SEQ_GEN_GAP_EN adds LFSR gaps.
module seq_gen #(
  parameter int MAX_LEN = 16,
  parameter int REP_W   = 4
`ifdef SEQ_GEN_GAP_EN
  ,
  parameter int GAP_W   = 2
`endif
) (
  input logic     clk,
  input logic     rst_n,
  seq_gen_if.slave bus
);
  localparam int LEN_W = $clog2(MAX_LEN);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
`ifdef SEQ_GEN_GAP_EN
  localparam logic [1:0] GAP  = 2'd2;
`endif
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]         state;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   idx;
  logic [REP_W-1:0]   reps_q;
  logic [REP_W-1:0]   rep;
  logic               rdy_q;
  logic               out_q;
  logic               vld_q;
  logic               done_q;

  logic               wrap;
  logic               last;
  logic [LEN_W-1:0]   nxt_idx;
  logic [REP_W-1:0]   nxt_rep;

`ifdef SEQ_GEN_GAP_EN
  logic [7:0]         lfsr;
  logic               lfsr_fb;
  logic [GAP_W-1:0]   gap;
  logic [GAP_W-1:0]   g;

  // taps 8,6,5,4; the seed is non-zero so the sequence never locks up
  assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  assign g       = lfsr[GAP_W-1:0];
`endif

  assign wrap    = (idx == len_q);
  assign last    = wrap && (rep == reps_q);
  assign nxt_idx = wrap ? '0 : idx + 1'b1;
  assign nxt_rep = wrap ? rep + 1'b1 : rep;

  assign bus.ready   = rdy_q;
  assign bus.out     = out_q;
  assign bus.out_vld = vld_q;
  assign bus.done    = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      pat_q  <= '0;
      len_q  <= '0;
      reps_q <= '0;
      idx    <= '0;
      rep    <= '0;
      rdy_q  <= 1'b1;
      out_q  <= 1'b0;
      vld_q  <= 1'b0;
      done_q <= 1'b0;
`ifdef SEQ_GEN_GAP_EN
      lfsr   <= 8'hA5;
      gap    <= '0;
`endif
    end else if (state != IDLE && bus.abort) begin
      state  <= IDLE;
      rdy_q  <= 1'b1;
      out_q  <= 1'b0;
      vld_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start && !bus.abort) begin
            pat_q  <= bus.pattern;
            len_q  <= bus.len_m1;
            reps_q <= bus.reps_m1;
            idx    <= '0;
            rep    <= '0;
            // first bit is registered straight from the port
            out_q  <= bus.pattern[0];
            vld_q  <= 1'b1;
            rdy_q  <= 1'b0;
            state  <= SEND;
          end
        end
        SEND: begin
          if (last) begin
            state  <= DONE;
            out_q  <= 1'b0;
            vld_q  <= 1'b0;
            done_q <= 1'b1;
          end else begin
            idx <= nxt_idx;
            rep <= nxt_rep;
`ifdef SEQ_GEN_GAP_EN
            lfsr <= {lfsr[6:0], lfsr_fb};
            if (g != '0) begin
              state <= GAP;
              gap   <= g;
              out_q <= 1'b0;
              vld_q <= 1'b0;
            end else begin
              out_q <= pat_q[nxt_idx];
            end
`else
            out_q <= pat_q[nxt_idx];
`endif
          end
        end
`ifdef SEQ_GEN_GAP_EN
        GAP: begin
          // idx already points at the next bit
          if (gap == GAP_W'(1)) begin
            state <= SEND;
            out_q <= pat_q[idx];
            vld_q <= 1'b1;
          end else begin
            gap <= gap - 1'b1;
          end
        end
`endif
        DONE: begin
          done_q <= 1'b0;
          rdy_q  <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_gen.sv
// Scoreboard bench for seq_gen: expected bits queued at start, popped on out_vld.
// Covers reset, single/repeat/full frames, ignored start, abort, async reset.
module tb_seq_gen;
  localparam int MAX_LEN = 16;
  localparam int REP_W   = 4;
  localparam int LEN_W   = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_gen_if #(.MAX_LEN(MAX_LEN), .REP_W(REP_W)) bus ();

  seq_gen #(.MAX_LEN(MAX_LEN), .REP_W(REP_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  bit sb[$];

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_vld) begin
        if (sb.size() == 0) begin
          check("extra_bit", 1, 0);
        end else begin
          bit e;
          e = sb.pop_front();
          check("bit", 32'(bus.out), 32'(e));
        end
      end else begin
        check("out_idle", 32'(bus.out), 0);
      end
      if (bus.done) done_cnt++;
    end
  end

  task automatic run_frame(input logic [15:0] pat,
                           input logic [LEN_W-1:0] len,
                           input logic [REP_W-1:0] reps);
    int nbits;
    int cyc;
    int d0;
    nbits = (int'(len) + 1) * (int'(reps) + 1);
    @(negedge clk);
    d0 = done_cnt;
    bus.pattern = pat;
    bus.len_m1  = len;
    bus.reps_m1 = reps;
    bus.start   = 1'b1;
    for (int r = 0; r <= int'(reps); r++)
      for (int i = 0; i <= int'(len); i++)
        sb.push_back(pat[i]);
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    // captured values must be insensitive to later input changes
    bus.pattern = 16'($urandom);
    bus.len_m1  = LEN_W'($urandom);
    bus.reps_m1 = REP_W'($urandom);
    cyc = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (bus.done) break;
      if (cyc > 5000) begin
        check("done_timeout", 1, 0);
        break;
      end
    end
    check("done_lat", cyc, nbits + 1);
    check("ready_in_done", 32'(bus.ready), 0);
    @(negedge clk);
    #1;
    check("ready_after", 32'(bus.ready), 1);
    check("done_once", done_cnt - d0, 1);
    check("sb_empty", sb.size(), 0);
  endtask

  initial begin
    int d0;
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.pattern = '0;
    bus.len_m1  = '0;
    bus.reps_m1 = '0;

    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(bus.ready), 1);
    check("rst_out", 32'(bus.out), 0);
    check("rst_vld", 32'(bus.out_vld), 0);
    check("rst_done", 32'(bus.done), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", 32'(bus.ready), 1);
    check("idle_vld", 32'(bus.out_vld), 0);

    run_frame(16'h000D, 4'd3, 4'd0);
    run_frame(16'h0002, 4'd1, 4'd2);
    run_frame(16'hB2C5, 4'd15, 4'd15);
    run_frame(16'h0001, 4'd0, 4'd0);

    // ignored start at bit 2, abort at bit 4
    @(negedge clk);
    d0 = done_cnt;
    bus.pattern = 16'h005A;
    bus.len_m1  = 4'd7;
    bus.reps_m1 = 4'd0;
    bus.start   = 1'b1;
    for (int i = 0; i < 5; i++) sb.push_back(bus.pattern[i]);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 3) begin
        bus.start   = 1'b1;
        bus.pattern = 16'hFFFF;
        bus.len_m1  = 4'd15;
      end
      if (k == 4) bus.start = 1'b0;
      if (k == 5) bus.abort = 1'b1;
      if (k == 6) begin
        bus.abort = 1'b0;
        check("abort_vld", 32'(bus.out_vld), 0);
        check("abort_ready", 32'(bus.ready), 1);
        check("abort_done", 32'(bus.done), 0);
      end
    end
    repeat (3) @(negedge clk);
    #1;
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_sb", sb.size(), 0);

    // start with abort in IDLE: abort wins
    @(negedge clk);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("sa_ready", 32'(bus.ready), 1);
    check("sa_vld", 32'(bus.out_vld), 0);
    @(negedge clk);
    check("sa_vld2", 32'(bus.out_vld), 0);

    // async reset in the middle of a frame
    @(negedge clk);
    bus.pattern = 16'hFFFF;
    bus.len_m1  = 4'd15;
    bus.reps_m1 = 4'd3;
    bus.start   = 1'b1;
    for (int i = 0; i < 16; i++) sb.push_back(1'b1);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("pre_rst_vld", 32'(bus.out_vld), 1);
    rst_n = 1'b0;
    #1;
    check("arst_ready", 32'(bus.ready), 1);
    check("arst_out", 32'(bus.out), 0);
    check("arst_vld", 32'(bus.out_vld), 0);
    check("arst_done", 32'(bus.done), 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(16'h0005, 4'd2, 4'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
